// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-initiator Wishbone round-robin arbiter.
// State encoding and watchdog counter width.
package wb_arbiter_pkg;

    localparam logic ARB_IDLE   = 1'b0;
    localparam logic ARB_BUSY   = 1'b1;
    localparam int   WDOG_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = ARB_IDLE,
        ST_BUSY = ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/wb_arb_rr_sel.sv
// Round-robin winner selection for two requesters.
// A tie goes to the requester that did not hold the bus last.
module wb_arb_rr_sel (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       next_grant,
    output logic       any_req
);

    always_comb begin
        any_req    = |req;
        next_grant = 1'b0;
        case (req)
            2'b01:   next_grant = 1'b0;
            2'b10:   next_grant = 1'b1;
            2'b11:   next_grant = ~last_grant;
            default: next_grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_arbiter_2x1.sv
// Two-initiator Wishbone arbiter: registered round-robin grant held for the whole cyc,
// with an optional stall watchdog that aborts a hung transfer with a one-cycle err.
//
// state | meaning
// IDLE  | no owner; requests are arbitrated, target sees t_cyc=0
// BUSY  | initiator[grant] owns the target until it drops cyc
module wb_arbiter_2x1
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned DAT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,

    input  logic [ADR_WIDTH-1:0]   i0_adr,
    input  logic [DAT_WIDTH-1:0]   i0_dat_w,
    input  logic [DAT_WIDTH/8-1:0] i0_sel,
    input  logic                   i0_we,
    input  logic                   i0_cyc,
    input  logic                   i0_stb,
    output logic [DAT_WIDTH-1:0]   i0_dat_r,
    output logic                   i0_ack,
    output logic                   i0_err,

    input  logic [ADR_WIDTH-1:0]   i1_adr,
    input  logic [DAT_WIDTH-1:0]   i1_dat_w,
    input  logic [DAT_WIDTH/8-1:0] i1_sel,
    input  logic                   i1_we,
    input  logic                   i1_cyc,
    input  logic                   i1_stb,
    output logic [DAT_WIDTH-1:0]   i1_dat_r,
    output logic                   i1_ack,
    output logic                   i1_err,

    output logic [ADR_WIDTH-1:0]   t_adr,
    output logic [DAT_WIDTH-1:0]   t_dat_w,
    output logic [DAT_WIDTH/8-1:0] t_sel,
    output logic                   t_we,
    output logic                   t_cyc,
    output logic                   t_stb,
    input  logic [DAT_WIDTH-1:0]   t_dat_r,
    input  logic                   t_ack,
    input  logic                   t_err
);

    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_t            state, state_nxt;
    logic                  grant, grant_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  wdog_trip, wdog_trip_nxt;
    logic [WDOG_WIDTH-1:0] wdog, wdog_nxt;

    logic [1:0] req;
    logic       sel_grant;
    logic       any_req;
    logic       gnt_cyc;
    logic       gnt_stb;
    logic       resp_ack;
    logic       resp_err;

    assign req     = {i1_cyc & i1_stb, i0_cyc & i0_stb};
    assign gnt_cyc = grant ? i1_cyc : i0_cyc;
    assign gnt_stb = grant ? i1_stb : i0_stb;

    wb_arb_rr_sel u_rr_sel (
        .req        (req),
        .last_grant (last_grant),
        .next_grant (sel_grant),
        .any_req    (any_req)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wdog       <= '0;
            wdog_trip  <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            wdog       <= wdog_nxt;
            wdog_trip  <= wdog_trip_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        wdog_nxt       = wdog;
        wdog_trip_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                wdog_nxt = '0;
                if (any_req) begin
                    grant_nxt = sel_grant;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!gnt_cyc) begin
                    state_nxt      = ST_IDLE;
                    last_grant_nxt = grant;
                    wdog_nxt       = '0;
                end else if (wdog_trip || t_ack || t_err) begin
                    wdog_nxt = '0;
                end else if ((TIMEOUT_CYCLES != 0) && t_stb) begin
                    // t_stb is already masked by state/abort, so this is a true stall
                    if (wdog == WDOG_LAST) begin
                        wdog_trip_nxt = 1'b1;
                        wdog_nxt      = '0;
                    end else begin
                        wdog_nxt = wdog + WDOG_WIDTH'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        t_adr    = '0;
        t_dat_w  = '0;
        t_sel    = '0;
        t_we     = 1'b0;
        t_cyc    = 1'b0;
        t_stb    = 1'b0;
        resp_ack = 1'b0;
        resp_err = 1'b0;
        if (state == ST_BUSY) begin
            t_adr    = grant ? i1_adr   : i0_adr;
            t_dat_w  = grant ? i1_dat_w : i0_dat_w;
            t_sel    = grant ? i1_sel   : i0_sel;
            t_we     = grant ? i1_we    : i0_we;
            t_cyc    = gnt_cyc & ~wdog_trip;
            t_stb    = gnt_stb & ~wdog_trip;
            // a late ack landing in the abort cycle must not reach the initiator
            resp_ack = t_ack & ~wdog_trip;
            resp_err = t_err | wdog_trip;
        end
        i0_ack = resp_ack & ~grant;
        i0_err = resp_err & ~grant;
        i1_ack = resp_ack & grant;
        i1_err = resp_err & grant;
    end

    assign i0_dat_r = t_dat_r;
    assign i1_dat_r = t_dat_r;

endmodule
